// File: rtl/mctrl_pkg.sv
// Shared types and constants for the multi-cycle control unit.
// States, opcodes, IR field positions and the reset PC default.
package mctrl_pkg;

    typedef enum logic [2:0] {
        S_FETCH   = 3'd0,
        S_DECODE  = 3'd1,
        S_EXECUTE = 3'd2,
        S_MEM     = 3'd3,
        S_WB      = 3'd4,
        S_ERROR   = 3'd5
    } state_t;

    // What EXECUTE does next for the decoded instruction
    typedef enum logic [1:0] {
        CLS_WB,
        CLS_MEM,
        CLS_BRANCH,
        CLS_JUMP
    } class_t;

    localparam logic [2:0] OP_ADD   = 3'b000;
    localparam logic [2:0] OP_ADDI  = 3'b001;
    localparam logic [2:0] OP_SHIFT = 3'b010;
    localparam logic [2:0] OP_ROT   = 3'b011;
    localparam logic [2:0] OP_BEQZ  = 3'b100;
    localparam logic [2:0] OP_SW    = 3'b101;
    localparam logic [2:0] OP_LW    = 3'b110;
    localparam logic [2:0] OP_JUMP  = 3'b111;

    localparam int OP_MSB    = 15;
    localparam int OP_LSB    = 13;
    localparam int RD_MSB    = 12;
    localparam int RD_LSB    = 10;
    localparam int RS_MSB    = 9;
    localparam int RS_LSB    = 7;
    localparam int RT_MSB    = 6;
    localparam int RT_LSB    = 4;
    localparam int SHIFT_BIT = 6;
    localparam int IMM7_MSB  = 6;
    localparam int IMM4_MSB  = 3;

    localparam logic [15:0] RESET_PC_DEFAULT = 16'h0000;

    function automatic logic [15:0] sext7(input logic [6:0] v);
        return {{9{v[6]}}, v};
    endfunction

endpackage

// File: rtl/mctrl_decode.sv
// Combinational instruction decode: register addresses, immediate,
// operand select, writeback source and the post-EXECUTE action class.
module mctrl_decode
    import mctrl_pkg::*;
(
    input  logic [15:0] ir,
    input  logic        execute,
    output logic [2:0]  rs_addr,
    output logic [2:0]  rt_addr,
    output logic [15:0] imm,
    output logic        alu_src_imm,
    output logic        wb_sel_mem,
    output class_t      cls
);

    logic [2:0] op;

    assign op          = ir[OP_MSB:OP_LSB];
    assign rs_addr     = ir[RS_MSB:RS_LSB];
    assign rt_addr     = (op == OP_SW) ? ir[RD_MSB:RD_LSB]
                                       : ir[RT_MSB:RT_LSB];
    assign alu_src_imm = (op != OP_ADD);
    assign wb_sel_mem  = (op == OP_LW);

    always_comb begin
        imm = sext7(ir[IMM7_MSB:0]);
        cls = CLS_WB;
        unique case (op)
            OP_ADD:           imm = '0;
            OP_SHIFT, OP_ROT: imm = {12'h000, ir[IMM4_MSB:0]};
            // beqz compares rs against zero while the branch executes
            OP_BEQZ: begin
                cls = CLS_BRANCH;
                if (execute) imm = '0;
            end
            OP_SW, OP_LW:     cls = CLS_MEM;
            OP_JUMP:          cls = CLS_JUMP;
            default:          ;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle control FSM owning PC and IR for the 16-bit datapath.
// Optional memory-ack timeout enabled by defining MCTRL_TIMEOUT_EN.
module multicycle_control
    import mctrl_pkg::*;
#(
    parameter logic [15:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          TIMEOUT  = 255
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        Enable,
    output logic        Imem_Req,
    output logic [15:0] Imem_Addr,
    input  logic        Imem_Ack,
    input  logic [15:0] Imem_Rdata,
    output logic [2:0]  Rs_Addr,
    output logic [2:0]  Rt_Addr,
    output logic [15:0] Imm_Out,
    output logic [2:0]  Alu_Opcode,
    output logic        Shift,
    output logic        Alu_Src_Imm,
    input  logic        Alu_Zero,
    input  logic [15:0] Alu_Result,
    output logic        Dmem_Req,
    output logic        Dmem_We,
    input  logic        Dmem_Ack,
    output logic        Reg_We,
    output logic [2:0]  Reg_Waddr,
    output logic        Wb_Sel_Mem,
    output logic [2:0]  State_Out,
    output logic        Bus_Error
);

    state_t      state;
    logic [15:0] pc;
    logic [15:0] ir;
    logic        bus_err;
    logic [2:0]  op;
    class_t      cls;
    logic [15:0] pc_inc;
    logic [15:0] br_target;
    logic        wait_expired;

    assign op        = ir[OP_MSB:OP_LSB];
    assign pc_inc    = pc + 16'd1;
    assign br_target = pc_inc + sext7(ir[IMM7_MSB:0]);

    mctrl_decode u_decode (
        .ir          (ir),
        .execute     (state == S_EXECUTE),
        .rs_addr     (Rs_Addr),
        .rt_addr     (Rt_Addr),
        .imm         (Imm_Out),
        .alu_src_imm (Alu_Src_Imm),
        .wb_sel_mem  (Wb_Sel_Mem),
        .cls         (cls)
    );

    // Gated by reset so no fetch request is visible while held in reset
    assign Imem_Req   = Reset_n && Enable && (state == S_FETCH);
    assign Imem_Addr  = pc;
    assign Dmem_Req   = (state == S_MEM);
    assign Dmem_We    = (state == S_MEM) && (op == OP_SW);
    assign Reg_We     = (state == S_WB);
    assign Reg_Waddr  = ir[RD_MSB:RD_LSB];
    assign Alu_Opcode = op;
    assign Shift      = ir[SHIFT_BIT];
    assign State_Out  = state;
    assign Bus_Error  = bus_err;

`ifdef MCTRL_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CNT_W-1:0] wait_cnt;
    logic             mem_wait;

    assign mem_wait = Imem_Req ? !Imem_Ack
                               : ((state == S_MEM) && !Dmem_Ack);
    assign wait_expired = mem_wait &&
                          (wait_cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) wait_cnt <= '0;
        else if (mem_wait) wait_cnt <= wait_cnt + 1'b1;
        else wait_cnt <= '0;
    end
`else
    assign wait_expired = 1'b0;
`endif

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state   <= S_FETCH;
            pc      <= RESET_PC;
            ir      <= '0;
            bus_err <= 1'b0;
        end else begin
            unique case (state)
                S_FETCH: begin
                    if (Imem_Req && Imem_Ack) begin
                        ir    <= Imem_Rdata;
                        state <= S_DECODE;
                    end else if (wait_expired) begin
                        state   <= S_ERROR;
                        bus_err <= 1'b1;
                    end
                end
                S_DECODE: state <= S_EXECUTE;
                S_EXECUTE: begin
                    unique case (cls)
                        CLS_WB:  state <= S_WB;
                        CLS_MEM: state <= S_MEM;
                        CLS_BRANCH: begin
                            pc    <= Alu_Zero ? br_target : pc_inc;
                            state <= S_FETCH;
                        end
                        CLS_JUMP: begin
                            pc    <= Alu_Result;
                            state <= S_FETCH;
                        end
                    endcase
                end
                S_MEM: begin
                    if (Dmem_Ack) begin
                        if (op == OP_SW) begin
                            pc    <= pc_inc;
                            state <= S_FETCH;
                        end else begin
                            state <= S_WB;
                        end
                    end else if (wait_expired) begin
                        state   <= S_ERROR;
                        bus_err <= 1'b1;
                    end
                end
                S_WB: begin
                    pc    <= pc_inc;
                    state <= S_FETCH;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: directed table, random instruction stream
// against a per-instruction state-sequence model, reset and timeout cases.
module tb_multicycle_control;

    localparam int FETCH   = 0;
    localparam int DECODE  = 1;
    localparam int EXECUTE = 2;
    localparam int MEM     = 3;
    localparam int WB      = 4;
    localparam int ERROR   = 5;
    localparam logic [15:0] RST_PC = 16'h0000;
`ifdef MCTRL_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        Enable = 1'b0;
    logic        Imem_Req;
    logic [15:0] Imem_Addr;
    logic        Imem_Ack;
    logic [15:0] Imem_Rdata;
    logic [2:0]  Rs_Addr;
    logic [2:0]  Rt_Addr;
    logic [15:0] Imm_Out;
    logic [2:0]  Alu_Opcode;
    logic        Shift;
    logic        Alu_Src_Imm;
    logic        Alu_Zero = 1'b0;
    logic [15:0] Alu_Result = 16'h0000;
    logic        Dmem_Req;
    logic        Dmem_We;
    logic        Dmem_Ack;
    logic        Reg_We;
    logic [2:0]  Reg_Waddr;
    logic        Wb_Sel_Mem;
    logic [2:0]  State_Out;
    logic        Bus_Error;

    multicycle_control #(
        .RESET_PC (RST_PC),
        .TIMEOUT  (8)
    ) dut (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .Enable      (Enable),
        .Imem_Req    (Imem_Req),
        .Imem_Addr   (Imem_Addr),
        .Imem_Ack    (Imem_Ack),
        .Imem_Rdata  (Imem_Rdata),
        .Rs_Addr     (Rs_Addr),
        .Rt_Addr     (Rt_Addr),
        .Imm_Out     (Imm_Out),
        .Alu_Opcode  (Alu_Opcode),
        .Shift       (Shift),
        .Alu_Src_Imm (Alu_Src_Imm),
        .Alu_Zero    (Alu_Zero),
        .Alu_Result  (Alu_Result),
        .Dmem_Req    (Dmem_Req),
        .Dmem_We     (Dmem_We),
        .Dmem_Ack    (Dmem_Ack),
        .Reg_We      (Reg_We),
        .Reg_Waddr   (Reg_Waddr),
        .Wb_Sel_Mem  (Wb_Sel_Mem),
        .State_Out   (State_Out),
        .Bus_Error   (Bus_Error)
    );

    always #5 Clk = ~Clk;

    // Memory models: ack after a programmed number of wait cycles;
    // while no request is pending, random stray acks are presented.
    logic [15:0] imem [0:65535];
    int   iwait = 0;
    int   dwait = 0;
    int   icnt;
    int   dcnt;
    logic spur_i = 1'b0;
    logic spur_d = 1'b0;

    always @(posedge Clk) begin
        icnt <= (Imem_Req && !Imem_Ack) ? icnt + 1 : 0;
        dcnt <= (Dmem_Req && !Dmem_Ack) ? dcnt + 1 : 0;
    end

    assign Imem_Ack   = Imem_Req ? (icnt >= iwait) : spur_i;
    assign Dmem_Ack   = Dmem_Req ? (dcnt >= dwait) : spur_d;
    assign Imem_Rdata = imem[Imem_Addr];

    int          nvec = 0;
    int          nmis = 0;
    logic [15:0] mpc  = RST_PC;

    task automatic chk(input string nm, input logic [15:0] act,
                       input logic [15:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %h expected %h (pc %h, t=%0t)",
                     nm, act, exp, mpc, $time);
        end
    endtask

    // One instruction from FETCH back to FETCH. Called at a negedge.
    task automatic run_instr(input logic [15:0] ins, input logic zero,
                             input logic [15:0] res, input int idle,
                             input int iw, input int dw);
        logic [2:0]  op;
        logic [15:0] nxt;
        logic [15:0] sx;
        logic [15:0] imm;
        int          plan[$];
        int          st;
        op = ins[15:13];
        sx = {{9{ins[6]}}, ins[6:0]};
        for (int k = 0; k < idle + iw + 1; k++) plan.push_back(FETCH);
        plan.push_back(DECODE);
        plan.push_back(EXECUTE);
        if (op == 3'd5 || op == 3'd6)
            for (int k = 0; k <= dw; k++) plan.push_back(MEM);
        if (op <= 3'd3 || op == 3'd6) plan.push_back(WB);
        if (op == 3'd4) nxt = zero ? mpc + 16'd1 + sx : mpc + 16'd1;
        else if (op == 3'd7) nxt = res;
        else nxt = mpc + 16'd1;
        imem[mpc]  = ins;
        Alu_Zero   = zero;
        Alu_Result = res;
        iwait      = iw;
        dwait      = dw;
        foreach (plan[k]) begin
            Enable = (k >= idle);
            spur_i = 1'($urandom);
            spur_d = 1'($urandom);
            #1;
            st = plan[k];
            chk("state", 16'(State_Out), 16'(st));
            chk("imem_req", 16'(Imem_Req), 16'(st == FETCH && k >= idle));
            chk("imem_addr", Imem_Addr, mpc);
            chk("dmem_req", 16'(Dmem_Req), 16'(st == MEM));
            chk("dmem_we", 16'(Dmem_We), 16'(st == MEM && op == 3'd5));
            chk("reg_we", 16'(Reg_We), 16'(st == WB));
            chk("bus_error", 16'(Bus_Error), 16'h0);
            if (st != FETCH) begin
                if (op == 3'd0) imm = 16'h0;
                else if (op == 3'd2 || op == 3'd3) imm = {12'h0, ins[3:0]};
                else if (op == 3'd4 && st == EXECUTE) imm = 16'h0;
                else imm = sx;
                chk("alu_opcode", 16'(Alu_Opcode), 16'(op));
                chk("shift", 16'(Shift), 16'(ins[6]));
                chk("rs_addr", 16'(Rs_Addr), 16'(ins[9:7]));
                if (op == 3'd0) chk("rt_addr", 16'(Rt_Addr), 16'(ins[6:4]));
                if (op == 3'd5) chk("rt_addr", 16'(Rt_Addr), 16'(ins[12:10]));
                chk("imm_out", Imm_Out, imm);
                chk("alu_src_imm", 16'(Alu_Src_Imm), 16'(op != 3'd0));
                chk("reg_waddr", 16'(Reg_Waddr), 16'(ins[12:10]));
                chk("wb_sel_mem", 16'(Wb_Sel_Mem), 16'(op == 3'd6));
            end
            @(negedge Clk);
        end
        #1;
        chk("state_end", 16'(State_Out), 16'(FETCH));
        chk("next_pc", Imem_Addr, nxt);
        mpc = nxt;
    endtask

    task automatic chk_reset_outputs();
        chk("rst_state", 16'(State_Out), 16'(FETCH));
        chk("rst_pc", Imem_Addr, RST_PC);
        chk("rst_imem_req", 16'(Imem_Req), 16'h0);
        chk("rst_dmem_req", 16'(Dmem_Req), 16'h0);
        chk("rst_dmem_we", 16'(Dmem_We), 16'h0);
        chk("rst_reg_we", 16'(Reg_We), 16'h0);
        chk("rst_bus_error", 16'(Bus_Error), 16'h0);
        chk("rst_alu_src_imm", 16'(Alu_Src_Imm), 16'h0);
        chk("rst_wb_sel_mem", 16'(Wb_Sel_Mem), 16'h0);
    endtask

    typedef struct {
        logic [15:0] ins;
        logic        zero;
        logic [15:0] res;
        int          idle;
        int          iw;
        int          dw;
        logic [15:0] exp_pc;
    } vec_t;

    vec_t tbl[15];

    initial begin
        logic [15:0] ins;
        logic [15:0] res;
        logic        zero;
        int          idle;
        int          iw;
        int          dw;

        tbl[0]  = '{16'h0530, 1'b0, 16'h0000, 0, 0, 0, 16'h0001};
        tbl[1]  = '{16'hD085, 1'b0, 16'h0000, 0, 0, 3, 16'h0002};
        tbl[2]  = '{16'hE000, 1'b0, 16'h0005, 2, 1, 0, 16'h0005};
        tbl[3]  = '{16'h80FE, 1'b1, 16'h0000, 0, 0, 0, 16'h0004};
        tbl[4]  = '{16'hE000, 1'b0, 16'h0005, 0, 2, 0, 16'h0005};
        tbl[5]  = '{16'h80FE, 1'b0, 16'h0000, 0, 0, 0, 16'h0006};
        tbl[6]  = '{16'hAC83, 1'b0, 16'h0000, 0, 1, 2, 16'h0007};
        tbl[7]  = '{16'hE000, 1'b0, 16'h0040, 0, 0, 0, 16'h0040};
        tbl[8]  = '{16'h29FF, 1'b0, 16'h0000, 1, 0, 0, 16'h0041};
        tbl[9]  = '{16'h44CA, 1'b1, 16'h0000, 0, 0, 0, 16'h0042};
        tbl[10] = '{16'hE000, 1'b0, 16'hFFFF, 0, 0, 0, 16'hFFFF};
        tbl[11] = '{16'h0530, 1'b0, 16'h0000, 0, 0, 0, 16'h0000};
        tbl[12] = '{16'hE000, 1'b0, 16'hFFFE, 0, 0, 0, 16'hFFFE};
        tbl[13] = '{16'h8003, 1'b1, 16'h0000, 0, 0, 0, 16'h0002};
        tbl[14] = '{16'h6907, 1'b0, 16'h0000, 0, 3, 0, 16'h0003};

        // Enable high during reset: the fetch request must still be low
        Reset_n = 1'b0;
        Enable  = 1'b1;
        #2;
        chk_reset_outputs();
        repeat (3) @(negedge Clk);
        Reset_n = 1'b1;
        mpc = RST_PC;

        foreach (tbl[i]) begin
            run_instr(tbl[i].ins, tbl[i].zero, tbl[i].res,
                      tbl[i].idle, tbl[i].iw, tbl[i].dw);
            chk("tbl_pc", Imem_Addr, tbl[i].exp_pc);
        end

        for (int n = 0; n < 200; n++) begin
            ins  = 16'($urandom);
            res  = 16'($urandom);
            zero = 1'($urandom);
            idle = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
            iw   = int'($urandom_range(0, 3));
            dw   = int'($urandom_range(0, 3));
            run_instr(ins, zero, res, idle, iw, dw);
        end

        // Reset in the middle of a store's memory phase
        imem[mpc] = 16'hAC83;
        iwait  = 0;
        dwait  = 20;
        spur_i = 1'b0;
        spur_d = 1'b0;
        Enable = 1'b1;
        repeat (3) @(negedge Clk);
        #1;
        chk("sw_in_mem", 16'(State_Out), 16'(MEM));
        chk("sw_dmem_req", 16'(Dmem_Req), 16'h1);
        chk("sw_dmem_we", 16'(Dmem_We), 16'h1);
        #2;
        Reset_n = 1'b0;
        #1;
        chk_reset_outputs();
        @(negedge Clk);
        Reset_n = 1'b1;
        Enable  = 1'b0;
        mpc     = RST_PC;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("post_rst_state", 16'(State_Out), 16'(FETCH));
            chk("post_rst_dmem_req", 16'(Dmem_Req), 16'h0);
            chk("post_rst_dmem_we", 16'(Dmem_We), 16'h0);
            chk("post_rst_reg_we", 16'(Reg_We), 16'h0);
            chk("post_rst_pc", Imem_Addr, RST_PC);
            @(negedge Clk);
        end
        run_instr(16'h0530, 1'b0, 16'h0000, 0, 0, 0);

        // Instruction memory never answers
        imem[mpc] = 16'h0530;
        iwait = 1000000;
        for (int k = 0; k < 14; k++) begin
            Enable = 1'b1;
            spur_i = 1'($urandom);
            spur_d = 1'($urandom);
            #1;
            if (TMO_EN && k >= 8) begin
                chk("tmo_state", 16'(State_Out), 16'(ERROR));
                chk("tmo_bus_error", 16'(Bus_Error), 16'h1);
                chk("tmo_imem_req", 16'(Imem_Req), 16'h0);
            end else begin
                chk("wait_state", 16'(State_Out), 16'(FETCH));
                chk("wait_bus_error", 16'(Bus_Error), 16'h0);
                chk("wait_imem_req", 16'(Imem_Req), 16'h1);
            end
            chk("wait_dmem_req", 16'(Dmem_Req), 16'h0);
            chk("wait_reg_we", 16'(Reg_We), 16'h0);
            chk("wait_pc", Imem_Addr, mpc);
            @(negedge Clk);
        end
        Reset_n = 1'b0;
        #1;
        chk_reset_outputs();
        @(negedge Clk);
        Reset_n = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multi-cycle control FSM that sequences the 16-bit ALU datapath through fetch, decode, execute, memory and writeback for each instruction.
- Owns the PC and the instruction register (IR).
- Drives Alu_Opcode, Shift and the operand-select control.
- Handshakes with instruction and data memories using req/ack.
- Sits between the memory system and the register file/ALU datapath.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.
- TIMEOUT, 255, maximum wait cycles for a memory ack (used only with MCTRL_TIMEOUT_EN).

Ports:
- Clk  in  1  system clock, rising edge.
- Reset_n  in  1  asynchronous active-low reset.
- Enable  in  1  allows a new fetch to start.
- Imem_Req  out  1  instruction fetch request.
- Imem_Addr  out  16  equals PC.
- Imem_Ack  in  1  fetch complete; Imem_Rdata valid.
- Imem_Rdata  in  16  instruction word.
- Rs_Addr  out  3  register-file read port A, IR[9:7].
- Rt_Addr  out  3  read port B: IR[6:4] for add, IR[12:10] for sw.
- Imm_Out  out  16  immediate for ALU operand 2.
- Alu_Opcode  out  3  equals IR[15:13].
- Shift  out  1  shift/rotate direction (1 = right), equals IR[6].
- Alu_Src_Imm  out  1  1 selects Imm_Out as operand 2.
- Alu_Zero  in  1  ALU zero flag.
- Alu_Result  in  16  ALU result, used as jump target.
- Dmem_Req  out  1  data memory request.
- Dmem_We  out  1  1 = store.
- Dmem_Ack  in  1  data access complete.
- Reg_We  out  1  register-file write strobe.
- Reg_Waddr  out  3  equals IR[12:10].
- Wb_Sel_Mem  out  1  1 = writeback from memory data, 0 = from ALU.
- State_Out  out  3  current FSM state (debug).
- Bus_Error  out  1  sticky timeout error.

Behaviour:
- Reset (async, Reset_n low):
  - State goes to FETCH; PC = RESET_PC; IR = 0.
  - All strobes (Imem_Req, Dmem_Req, Dmem_We, Reg_We) are 0; Bus_Error = 0; Alu_Src_Imm = 0; Wb_Sel_Mem = 0.
  - Reset mid-transaction abandons the transaction; no write strobe may fire.
- States: FETCH=0, DECODE=1, EXECUTE=2, MEM=3, WB=4, ERROR=5.
- FETCH:
  - Imem_Req = Enable.
  - On Imem_Req && Imem_Ack (same-cycle ack allowed): IR <= Imem_Rdata, go to DECODE.
  - Enable low: stay in FETCH, no request.
- DECODE: one cycle; register-file addresses and Imm_Out are stable.
- Imm_Out by opcode:
  - 000: 0.
  - 010, 011: zero-extended IR[3:0].
  - 100 (beqz) during EXECUTE: 0.
  - All other opcodes: sign-extended IR[6:0].
- Alu_Src_Imm: 0 for opcode 000, 1 otherwise.
- EXECUTE: one cycle; Alu_Opcode and Shift are valid. Next action by opcode:
  - 000, 001, 010, 011: go to WB.
  - 101 (sw), 110 (lw): go to MEM.
  - 100 (beqz): if Alu_Zero, PC <= PC + 1 + sext(IR[6:0]), else PC <= PC + 1; go to FETCH.
  - 111 (jump): PC <= Alu_Result; go to FETCH.
- MEM:
  - Dmem_Req = 1; Dmem_We = 1 for opcode 101.
  - Wait for Dmem_Ack.
  - sw on ack: PC <= PC + 1, go to FETCH.
  - lw on ack: go to WB.
- WB:
  - Reg_We = 1 for exactly one cycle; Wb_Sel_Mem = 1 for opcode 110.
  - PC <= PC + 1; go to FETCH.
- Latency with zero-wait acks:
  - ALU ops: 4 cycles.
  - lw: 5 cycles.
  - sw: 4 cycles.
  - beqz, jump: 3 cycles.
- PC arithmetic: 16-bit modulo; 16'hFFFF + 1 wraps to 0; branch offset wraps the same way.
- Strobe rules:
  - Req held until ack; no back-to-back request without a state change.
  - An ack arriving in a state not expecting it is ignored.

Optional Feature:
- MCTRL_TIMEOUT_EN defined:
  - A wait counter runs in FETCH (while Imem_Req is asserted) and in MEM.
  - If no ack arrives within TIMEOUT cycles, go to ERROR and set Bus_Error.
  - In ERROR: all strobes 0; the state holds until reset.
- Not defined:
  - Acks are awaited indefinitely, Bus_Error is tied to 0, and ERROR is unreachable.

Decomposition:
- Package mctrl_pkg holds:
  - State encodings.
  - Opcode constants (OP_ADD..OP_JUMP).
  - IR field positions.
  - RESET_PC default.
- One sub-module, mctrl_decode: combinational IR to {Rs_Addr, Rt_Addr, Imm_Out, Alu_Src_Imm, Wb_Sel_Mem, next-class}.
- The FSM, PC and IR live in the top module.

Test Plan:
- Reset, Enable=1, zero-wait memories, IR = add r1,r2,r3 -> Imem_Req in cycle 0; Reg_We exactly in cycle 3 with Reg_Waddr=1; PC 0->1.
- lw with Dmem_Ack delayed 3 cycles -> Dmem_Req held 4 cycles, Dmem_We=0; Reg_We one cycle with Wb_Sel_Mem=1.
- beqz imm=-2 at PC=5: with Alu_Zero=1 -> PC=4; with Alu_Zero=0 -> PC=6; Reg_We never asserted.
- jump with Alu_Result=16'h0040 -> PC=16'h0040 after 3 cycles; next Imem_Addr=16'h0040.
- Reset_n asserted during MEM of sw -> Dmem_Req drops immediately, PC=RESET_PC, no Dmem_We pulse after release.
- With MCTRL_TIMEOUT_EN and TIMEOUT=8, Imem_Ack held 0 -> ERROR entered after 8 cycles, Bus_Error=1 sticky, Imem_Req=0.
